// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_MADD_EN to add madd/maddu (accumulate into {HI,LO} at commit).
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic             busyR;
    logic [CNT_W-1:0] cntR;
    logic [3:0]       opR;
    logic [63:0]      pendR;
    logic             divZeroR;
    logic [31:0]      hiR;
    logic [31:0]      loR;

    logic [31:0] absAS, absBS, dividendS, divisorS, quotS, remS;
    logic [63:0] prodSgnS, prodUnsS, resultS;
    logic        isMulS, isDivS;

    // Operand preparation: one shared unsigned divider, sign fixed up afterwards.
    always_comb begin
        absAS     = A[31] ? (32'd0 - A) : A;
        absBS     = B[31] ? (32'd0 - B) : B;
        prodSgnS  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prodUnsS  = {32'd0, A} * {32'd0, B};
        dividendS = A;
        divisorS  = B;
        if (MDOp == OP_DIV) begin
            dividendS = absAS;
            divisorS  = absBS;
        end else begin
            dividendS = A;
            divisorS  = B;
        end
        // Zero divisor is replaced so the divider never yields X; result is discarded.
        if (divisorS == 32'd0) begin
            divisorS = 32'd1;
        end else begin
            divisorS = divisorS;
        end
        quotS = dividendS / divisorS;
        remS  = dividendS % divisorS;
    end

    // Decode and pick the 64-bit {HI,LO} result for the requested op.
    always_comb begin
        isMulS  = 1'b0;
        isDivS  = 1'b0;
        resultS = 64'd0;
        case (MDOp)
            OP_MULT: begin
                isMulS  = 1'b1;
                resultS = prodSgnS;
            end
            OP_MULTU: begin
                isMulS  = 1'b1;
                resultS = prodUnsS;
            end
            OP_DIV: begin
                isDivS  = 1'b1;
                resultS = {(A[31] ? (32'd0 - remS) : remS),
                           ((A[31] ^ B[31]) ? (32'd0 - quotS) : quotS)};
            end
            OP_DIVU: begin
                isDivS  = 1'b1;
                resultS = {remS, quotS};
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                isMulS  = 1'b1;
                resultS = prodSgnS;
            end
            OP_MADDU: begin
                isMulS  = 1'b1;
                resultS = prodUnsS;
            end
`endif
            default: begin
                isMulS  = 1'b0;
                isDivS  = 1'b0;
                resultS = 64'd0;
            end
        endcase
    end

    // Sequencer: accept in IDLE, count down in RUN, commit on the final edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            busyR    <= 1'b0;
            cntR     <= '0;
            opR      <= 4'd0;
            pendR    <= 64'd0;
            divZeroR <= 1'b0;
            hiR      <= 32'd0;
            loR      <= 32'd0;
        end else if (busyR) begin
            if (cntR == '0) begin
                busyR <= 1'b0;
                if (((opR == OP_DIV) || (opR == OP_DIVU)) && divZeroR) begin
                    hiR <= hiR;
                    loR <= loR;
`ifdef MDU_MADD_EN
                end else if ((opR == OP_MADD) || (opR == OP_MADDU)) begin
                    {hiR, loR} <= {hiR, loR} + pendR;
`endif
                end else begin
                    {hiR, loR} <= pendR;
                end
            end else begin
                cntR <= cntR - 1'b1;
            end
        end else if (Start) begin
            if (isMulS || isDivS) begin
                busyR    <= 1'b1;
                opR      <= MDOp;
                pendR    <= resultS;
                divZeroR <= (B == 32'd0);
                cntR     <= isDivS ? DIV_LOAD : MULT_LOAD;
            end else if (MDOp == OP_MTHI) begin
                hiR <= A;
            end else if (MDOp == OP_MTLO) begin
                loR <= A;
            end else begin
                opR <= opR;
            end
        end else begin
            opR <= opR;
        end
    end

    assign Busy = busyR;
    assign HI   = hiR;
    assign LO   = loR;

endmodule
